// File: rtl/matrix_multiply_seq_if.sv
// Handshake and operand/result bundle for the sequential matrix multiplier.
interface matrix_multiply_seq_if #(
  parameter int N  = 2,
  parameter int W  = 2,
  parameter int OW = 2*W + $clog2(N)
);
  logic              start;
  logic              acc;
  logic [N*N*W-1:0]  A;
  logic [N*N*W-1:0]  B;
  logic [N*N*OW-1:0] C;
  logic              busy;
  logic              done;

  modport master (output start, acc, A, B, input  C, busy, done);
  modport slave  (input  start, acc, A, B, output C, busy, done);
endinterface

// File: rtl/matrix_multiply_seq.sv
// Sequential N x N unsigned matrix multiply(-accumulate): one MAC per cycle over
// (i,j,k) with k innermost; result committed to C atomically on entry to DONE.
module matrix_multiply_seq #(
  parameter  int N  = 2,
  parameter  int W  = 2,
  localparam int OW = 2*W + $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  matrix_multiply_seq_if.slave mm
);
  localparam int IW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  // Row-major packing with (0,0) in the MSBs means element (r,c) sits at [LAST-r][LAST-c].
  typedef logic [N-1:0][N-1:0][W-1:0]  mat_in_t;
  typedef logic [N-1:0][N-1:0][OW-1:0] mat_out_t;

  logic [1:0]    state;
  mat_in_t       a_q, b_q;
  logic          acc_q;
  logic [IW-1:0] i, j, k;
  logic [OW-1:0] accum;
  mat_out_t      cbuf, cbuf_nxt, c_q;
  logic [OW-1:0] prod, seed, sum;
  logic          last;

  assign last = (i == LAST) && (j == LAST) && (k == LAST);

  always_comb begin
    prod     = OW'(a_q[LAST-i][LAST-k]) * OW'(b_q[LAST-k][LAST-j]);
    seed     = (k == '0) ? (acc_q ? c_q[LAST-i][LAST-j] : '0) : accum;
    sum      = seed + prod;
    cbuf_nxt = cbuf;
    if (k == LAST) cbuf_nxt[LAST-i][LAST-j] = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= 1'b0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      accum <= '0;
      cbuf  <= '0;
      c_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mm.start) begin
            a_q   <= mm.A;
            b_q   <= mm.B;
            acc_q <= mm.acc;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          accum <= sum;
          cbuf  <= cbuf_nxt;
          if (k == LAST) begin
            k <= '0;
            if (j == LAST) begin
              j <= '0;
              i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
          // Last element goes straight into C so the whole matrix updates in one edge.
          if (last) begin
            i     <= '0;
            c_q   <= cbuf_nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mm.C    = c_q;
  assign mm.busy = (state == RUN);
  assign mm.done = (state == DONE);
endmodule

// File: tb/tb_matrix_multiply_seq.sv
// Bench for matrix_multiply_seq: cycle model + per-cycle compare for N=2,W=2,
// directed literal checks for both N=2,W=2 and N=3,W=4.
module tb_matrix_multiply_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_multiply_seq_if #(.N(2), .W(2)) if2 ();
  matrix_multiply_seq_if #(.N(3), .W(4)) if3 ();

  matrix_multiply_seq #(.N(2), .W(2)) dut2 (.clk(clk), .rst(rst), .mm(if2));
  matrix_multiply_seq #(.N(3), .W(4)) dut3 (.clk(clk), .rst(rst), .mm(if3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product for N=2, W=2: plain sums over k, result modulo 2^5.
  function automatic logic [19:0] mm2(input logic [7:0] a, input logic [7:0] b,
                                      input logic ac, input logic [19:0] cp);
    logic [19:0] r;
    int s;
    r = '0;
    for (int ii = 0; ii < 2; ii++)
      for (int jj = 0; jj < 2; jj++) begin
        s = ac ? int'(cp[(3-(ii*2+jj))*5 +: 5]) : 0;
        for (int kk = 0; kk < 2; kk++)
          s += int'(a[(3-(ii*2+kk))*2 +: 2]) * int'(b[(3-(kk*2+jj))*2 +: 2]);
        r[(3-(ii*2+jj))*5 +: 5] = 5'(s);
      end
    return r;
  endfunction

  // Timeline model: an accepted start keeps the block busy for 8 cycles, then
  // one done cycle in which C takes the product of the operands seen at acceptance.
  int          m_rem;
  logic        m_done;
  logic [19:0] m_c;
  logic [7:0]  la, lb;
  logic        lacc;
  logic        cmp_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_c = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_c = mm2(la, lb, lacc, m_c);
    end else begin
      m_done = 1'b0;
      if (if2.start) begin
        la = if2.A; lb = if2.B; lacc = if2.acc; m_rem = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 128'(if2.busy), 128'(m_rem > 0));
      chk("done", 128'(if2.done), 128'(m_done));
      chk("C",    128'(if2.C),    128'(m_c));
    end
  end

  task automatic go2(input logic [7:0] a, input logic [7:0] b, input logic ac,
                     output int lat, output int nb);
    if2.A = a; if2.B = b; if2.acc = ac; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (if2.busy) nb++;
    end while (!if2.done && lat < 60);
    if (!if2.done) chk("timeout2", 128'(lat), 128'd9);
  endtask

  int lat, nb, dn, last_d, nd;
  logic [7:0] ra, rb;

  initial begin
    rst = 1'b1;
    if2.start = 1'b0; if2.acc = 1'b0; if2.A = '0; if2.B = '0;
    if3.start = 1'b0; if3.acc = 1'b0; if3.A = '0; if3.B = '0;
    #1;
    chk("rst_C2", 128'(if2.C), 128'd0);
    chk("rst_busy2", 128'(if2.busy), 128'd0);
    chk("rst_done2", 128'(if2.done), 128'd0);
    chk("rst_C3", 128'(if3.C), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; cmp_en = 1'b1;
    @(posedge clk); #1;

    // Basic overwrite
    go2(8'b01_10_11_00, 8'b10_01_00_11, 1'b0, lat, nb);
    chk("basic_lat", 128'(lat), 128'd9);
    chk("basic_busy", 128'(nb), 128'd8);
    chk("basic_C", 128'(if2.C), 128'({5'd2, 5'd7, 5'd6, 5'd3}));
    chk("model_basic", 128'(m_c), 128'({5'd2, 5'd7, 5'd6, 5'd3}));
    @(posedge clk); #1;

    // Max values, then accumulate with wrap
    go2(8'hFF, 8'hFF, 1'b0, lat, nb);
    chk("max_C", 128'(if2.C), 128'({4{5'd18}}));
    @(posedge clk); #1;
    go2(8'hFF, 8'hFF, 1'b1, lat, nb);
    chk("acc_wrap_C", 128'(if2.C), 128'({4{5'd4}}));
    chk("model_wrap", 128'(m_c), 128'({4{5'd4}}));
    @(posedge clk); #1;

    // Operand/start churn during RUN must be ignored
    if2.A = 8'b01_10_11_00; if2.B = 8'hFF; if2.acc = 1'b0; if2.start = 1'b1;
    @(posedge clk); #1;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 7) begin
        if2.A = 8'($urandom); if2.B = 8'($urandom);
        if2.acc = 1'($urandom); if2.start = 1'($urandom);
      end else begin
        if2.start = 1'b0;
      end
      @(negedge clk);
      if (if2.done) dn++;
      @(posedge clk); #1;
    end
    chk("churn_dones", 128'(dn), 128'd1);
    chk("churn_C", 128'(if2.C), 128'({4{5'd9}}));

    // Back-to-back with start held high
    if2.acc = 1'b0; if2.start = 1'b1;
    last_d = -1; nd = 0;
    for (int c = 0; c < 45; c++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if2.A = ra; if2.B = rb; if2.acc = 1'($urandom);
      @(negedge clk);
      if (if2.done) begin
        if (last_d >= 0) chk("b2b_period", 128'(c - last_d), 128'd9);
        last_d = c; nd++;
      end
      @(posedge clk); #1;
    end
    if2.start = 1'b0;
    chk("b2b_count", 128'(nd >= 4), 128'd1);
    repeat (12) @(posedge clk);
    #1;

    // Reset in the fourth RUN cycle
    if2.A = 8'hFF; if2.B = 8'hFF; if2.acc = 1'b0; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstrun_C", 128'(if2.C), 128'd0);
    chk("rstrun_busy", 128'(if2.busy), 128'd0);
    chk("rstrun_done", 128'(if2.done), 128'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    go2(8'b01_10_11_00, 8'b10_01_00_11, 1'b0, lat, nb);
    chk("postrst_lat", 128'(lat), 128'd9);
    chk("postrst_C", 128'(if2.C), 128'({5'd2, 5'd7, 5'd6, 5'd3}));
    @(posedge clk); #1;

    // N=3, W=4: identity x B returns B zero-extended
    if3.A = {4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    if3.B = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    if3.acc = 1'b0; if3.start = 1'b1;
    @(posedge clk); #1;
    if3.start = 1'b0;
    lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (if3.busy) nb++;
    end while (!if3.done && lat < 60);
    chk("n3_lat", 128'(lat), 128'd28);
    chk("n3_busy", 128'(nb), 128'd27);
    chk("n3_C", 128'(if3.C), 128'({10'd1, 10'd2, 10'd3, 10'd4, 10'd5,
                                   10'd6, 10'd7, 10'd8, 10'd9}));
    @(negedge clk);
    chk("n3_done_pulse", 128'(if3.done), 128'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_multiply_seq.md
# matrix_multiply_seq

Parametrised, sequential successor to the combinational 2x2 matrix multiplier. It computes C = A x B, or C = C + A x B in accumulate mode, for N x N unsigned matrices of W-bit elements. It uses a single multiply-accumulate datapath stepped over all (i, j, k) index triples under a start/busy/done handshake. It sits in the arithmetic cluster wherever matrix products larger than 2x2, or repeated accumulation, are needed, trading latency for area.

## Interface
Parameters:
- N, 2: matrix dimension (N >= 2).
- W, 2: input element width in bits (W >= 1).
- OW, 2*W + clog2(N): output element width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new product; accepted only in IDLE or DONE.
- acc  input  1  sampled with start: 0 = overwrite (C = AxB), 1 = accumulate (C = C + AxB).
- A  input  N*N*W  matrix A, row-major packed; element (0,0) in the MSBs, element (N-1,N-1) in the LSBs (N=2: {a11,a12,a21,a22}).
- B  input  N*N*W  matrix B, same packing as A.
- C  output  N*N*OW  result matrix, same row-major packing, OW bits per element; registered.
- busy  output  1  high while computing (state RUN).
- done  output  1  one-cycle pulse; C has just been updated with a new result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch A, B and acc into internal registers; clear i=j=k=0; go to RUN.
- RUN: each cycle, add A[i][k]*B[k][j] (full 2W-bit product, zero-extended to OW) into the working accumulator for element (i,j).
  - At k=0 the accumulator is seeded with 0 (acc=0) or the current C[i][j] (acc=1).
  - Loop order: k innermost, then j, then i.
  - When k=N-1, write the element into the internal result buffer.
  - After the triple (N-1,N-1,N-1), go to DONE.
- DONE: copy the result buffer into C atomically, then pulse done=1 for exactly this cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start in RUN is ignored entirely; A, B and acc changes during RUN have no effect.
- Arithmetic is unsigned, modulo 2^OW.
  - Overwrite mode cannot overflow (N*(2^W-1)^2 < 2^OW).
  - Accumulate mode wraps silently.
- C changes only on entry to DONE and on reset; it holds its value in all other cycles.

## Timing
- Reset values: state=IDLE, C=0, busy=0, done=0, all counters and buffers 0.
- Reset asserted mid-RUN aborts the operation; C returns to 0 and no done pulse is issued.
- Start accepted at rising edge t: busy=1 during cycles t+1 .. t+N^3 (N^3 RUN cycles).
- DONE and the updated C are in cycle t+N^3+1, which is the start-to-done latency.
- busy=0 in the DONE cycle.
- Back-to-back: start held high in DONE makes the next RUN begin in the following cycle.
  - Throughput is therefore one result per N^3+1 cycles.
- done is never high in two consecutive cycles.

## Test plan
- Basic overwrite, N=2, W=2, A=8'b01_10_11_00, B=8'b10_01_00_11, acc=0 -> done exactly 9 cycles after start; C={5'd2,5'd7,5'd6,5'd3}; busy high for 8 cycles.
- Max values, N=2, W=2, all elements 3, acc=0 -> C={4{5'd18}}. Then repeat with acc=1 -> C={4{5'd4}} (36 mod 32 wrap).
- Handshake robustness: pulse start and change A/B every cycle during RUN -> result matches the operands latched at acceptance; exactly one done pulse.
- Back-to-back: hold start=1 continuously -> done pulses every 9 cycles (N=2); each C matches its latched operands.
- Reset mid-run: assert rst in cycle 4 of RUN -> C=0, busy=0, done=0 immediately. A fresh start after release yields a correct result.
- Scaling, N=3, W=4, A=identity, B elements 1..9 in row-major order -> done 28 cycles after start; C equals B with each element zero-extended to OW=10 bits.
